// File: rtl/inst_fetch_pkg.sv
// Shared types for the Risc-Inci instruction fetch stage.
// FETCH_MISALIGN_TRAP_EN adds the HALT state used for misaligned redirects.
package inst_fetch_pkg;

    localparam int cXLEN = 32;

    // Fetch FSM states; HALT only exists when the misalign trap is built in.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        S_HALT  = 3'd4
`endif
    } tFetchState;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [cXLEN-1:0] inst;
        logic [cXLEN-1:0] pc;
    } tFetchEntry;

    // Sequential PC step; wraps modulo 2^cXLEN.
    function automatic logic [cXLEN-1:0] pc_inc(input logic [cXLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding fetched {inst, pc} entries.
// Depth need not be a power of two, so pointers wrap explicitly.
// The head output reads as zero while the FIFO is empty.
module fetch_buf
    import inst_fetch_pkg::*;
#(
    parameter  int cDepth = 2,
    localparam int cCntW  = $clog2(cDepth + 1),
    localparam int cEntW  = $bits(tFetchEntry)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iClr,
    input  logic             iPush,
    input  logic [cEntW-1:0] iPushData,
    input  logic             iPop,
    output logic [cCntW-1:0] oCount,
    output logic [cEntW-1:0] oHead,
    output logic             oValid
);

    localparam int cPtrW = $clog2(cDepth);
    localparam logic [cPtrW-1:0] cLastPtr = cPtrW'(cDepth - 1);

    tFetchEntry       r_mem [cDepth];
    logic [cPtrW-1:0] r_wr_ptr;
    logic [cPtrW-1:0] r_rd_ptr;
    logic [cCntW-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [cPtrW-1:0] ptr_next(input logic [cPtrW-1:0] p);
        if (p == cLastPtr) begin
            return {cPtrW{1'b0}};
        end else begin
            return p + cPtrW'(1);
        end
    endfunction

    // Qualify push/pop against the current fill level.
    always_comb begin
        w_do_push = iPush && (int'(r_count) < cDepth);
        w_do_pop  = iPop && (r_count != {cCntW{1'b0}});
    end

    // Pointer and occupancy bookkeeping; clear empties the FIFO at once.
    always_ff @(posedge iClk) begin
        if (iRst || iClr) begin
            r_wr_ptr <= {cPtrW{1'b0}};
            r_rd_ptr <= {cPtrW{1'b0}};
            r_count  <= {cCntW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            r_count <= r_count + cCntW'(w_do_push) - cCntW'(w_do_pop);
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge iClk) begin
        if (w_do_push && !iClr && !iRst) begin
            r_mem[r_wr_ptr] <= tFetchEntry'(iPushData);
        end
    end

    assign oCount = r_count;
    assign oValid = (r_count != {cCntW{1'b0}});
    assign oHead  = oValid ? cEntW'(r_mem[r_rd_ptr]) : {cEntW{1'b0}};

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC generation, single-outstanding memory reads,
// and a small buffer feeding the decoder.
// Build option FETCH_MISALIGN_TRAP_EN: a misaligned redirect halts fetch
// and raises oMisalign instead of silently aligning the target.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [cXLEN-1:0] cResetPc  = 32'h0000_0000,
    parameter int               cBufDepth = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iFlushPipe,
    input  logic [cXLEN-1:0] iFlushPc,
    input  logic             iStall,
    output logic             oMemRd,
    output logic [cXLEN-1:0] oMemAddr,
    input  logic             iMemGnt,
    input  logic [cXLEN-1:0] iMemData,
    input  logic             iMemDv,
    output logic [cXLEN-1:0] oInst,
    output logic [cXLEN-1:0] oCurPc,
    output logic             oInstDv
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic             oMisalign
`endif
);

    localparam int cCntW = $clog2(cBufDepth + 1);

    tFetchState       r_state;
    logic [cXLEN-1:0] r_pc;
    logic [cXLEN-1:0] r_req_pc;
    logic             r_outstanding;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic             r_misalign;
    logic             w_misaligned;
`endif

    logic [cCntW-1:0] w_count;
    logic [cCntW-1:0] w_count_next;
    logic             w_valid;
    tFetchEntry       w_head;
    tFetchEntry       w_push_data;
    logic             w_push;
    logic             w_pop;
    logic             w_out_end;
    logic             w_credit;
    logic             w_req_window;
    logic             w_mem_rd;
    logic             w_grant;
    logic [cXLEN-1:0] w_target;
    logic             w_keep_out;

    // Request/credit decisions. oMemRd must react to iMemDv, iStall and
    // iFlushPipe in the same cycle to sustain one fetch per cycle, so it is
    // derived combinationally from registered state and those inputs.
    always_comb begin
        w_push       = (r_state == S_WAIT) && iMemDv && !iFlushPipe && !iRst;
        w_pop        = w_valid && !iStall;
        w_count_next = w_count + cCntW'(w_push) - cCntW'(w_pop);
        w_out_end    = r_outstanding && !iMemDv;
        w_credit     = ((32'(w_count_next) + 32'(w_out_end) + 32'd1) <= 32'(cBufDepth));
        if (r_state == S_FETCH) begin
            w_req_window = 1'b1;
        end else if (r_state == S_WAIT) begin
            w_req_window = iMemDv;
        end else begin
            w_req_window = 1'b0;
        end
        w_mem_rd    = w_req_window && w_credit && !iFlushPipe && !iRst;
        w_grant     = w_mem_rd && iMemGnt;
        w_keep_out  = r_outstanding && !iMemDv;
        w_push_data = '{inst: iMemData, pc: r_req_pc};
`ifdef FETCH_MISALIGN_TRAP_EN
        w_target     = iFlushPc;
        w_misaligned = (iFlushPc[1:0] != 2'b00);
`else
        w_target     = iFlushPc & ~32'h0000_0003;
`endif
    end

    // Fetch FSM: redirect beats every event except reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state       <= S_IDLE;
            r_pc          <= cResetPc;
            r_req_pc      <= 32'h0000_0000;
            r_outstanding <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misalign    <= 1'b0;
`endif
        end else if (iFlushPipe) begin
            r_outstanding <= w_keep_out;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_misaligned) begin
                r_state    <= S_HALT;
                r_misalign <= 1'b1;
            end else begin
                r_pc       <= w_target;
                r_misalign <= 1'b0;
                r_state    <= w_keep_out ? S_DRAIN : S_FETCH;
            end
`else
            r_pc    <= w_target;
            r_state <= w_keep_out ? S_DRAIN : S_FETCH;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (w_grant) begin
                        r_pc          <= pc_inc(r_pc);
                        r_req_pc      <= r_pc;
                        r_outstanding <= 1'b1;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (iMemDv) begin
                        if (w_grant) begin
                            r_pc          <= pc_inc(r_pc);
                            r_req_pc      <= r_pc;
                            r_outstanding <= 1'b1;
                        end else begin
                            r_outstanding <= 1'b0;
                            r_state       <= S_FETCH;
                        end
                    end
                end
                S_DRAIN: begin
                    if (iMemDv) begin
                        r_outstanding <= 1'b0;
                        r_state       <= S_FETCH;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                S_HALT: begin
                    if (iMemDv) begin
                        r_outstanding <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    fetch_buf #(
        .cDepth (cBufDepth)
    ) u_buf (
        .iClk      (iClk),
        .iRst      (iRst),
        .iClr      (iFlushPipe),
        .iPush     (w_push),
        .iPushData (w_push_data),
        .iPop      (w_pop),
        .oCount    (w_count),
        .oHead     (w_head),
        .oValid    (w_valid)
    );

    assign oMemRd   = w_mem_rd;
    assign oMemAddr = r_pc;
    assign oInst    = w_head.inst;
    assign oCurPc   = w_head.pc;
    assign oInstDv  = w_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign oMisalign = r_misalign;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a latency-configurable memory model,
// an expected-instruction queue filled by the tests, and a monitor that
// pops and compares every instruction the decoder would accept.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int cDepth = 2;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iFlushPipe = 1'b0;
    logic [31:0] iFlushPc = 32'h0;
    logic        iStall = 1'b0;
    logic        oMemRd;
    logic [31:0] oMemAddr;
    logic        iMemGnt = 1'b1;
    logic [31:0] iMemData = 32'h0;
    logic        iMemDv = 1'b0;
    logic [31:0] oInst;
    logic [31:0] oCurPc;
    logic        oInstDv;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        oMisalign;
`endif

    int checks = 0;
    int failures = 0;
    int ovf_cnt = 0;

    int          mem_lat = 1;
    logic        mem_pend = 1'b0;
    int          mem_left = 0;
    logic [31:0] mem_addr = 32'h0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    inst_fetch #(
        .cResetPc  (32'h0000_0000),
        .cBufDepth (cDepth)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iFlushPipe (iFlushPipe),
        .iFlushPc   (iFlushPc),
        .iStall     (iStall),
        .oMemRd     (oMemRd),
        .oMemAddr   (oMemAddr),
        .iMemGnt    (iMemGnt),
        .iMemData   (iMemData),
        .iMemDv     (iMemDv),
        .oInst      (oInst),
        .oCurPc     (oCurPc),
        .oInstDv    (oInstDv)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .oMisalign  (oMisalign)
`endif
    );

    always #5 iClk = ~iClk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0000};
    endfunction

    task automatic sb_expect(input logic [31:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = start + 32'(i * 4);
            e.inst = mem_word(e.pc);
            sb_q.push_back(e);
        end
    endtask

    // Memory: drives data at the falling edge, samples the handshake later.
    always begin
        @(negedge iClk);
        iMemDv = 1'b0;
        if (mem_pend) begin
            mem_left = mem_left - 1;
            if (mem_left == 0) begin
                iMemDv   = 1'b1;
                iMemData = mem_word(mem_addr);
                mem_pend = 1'b0;
            end
        end
        #3;
        if (oMemRd && iMemGnt) begin
            mem_pend = 1'b1;
            mem_left = mem_lat;
            mem_addr = oMemAddr;
        end
    end

    // Scoreboard monitor plus push-into-full watch.
    always begin
        @(negedge iClk);
        #2;
        if (!iRst && dut.w_push && (int'(dut.w_count) == cDepth)) begin
            ovf_cnt = ovf_cnt + 1;
        end
        if (!iRst && oInstDv && !iStall && !iFlushPipe && sb_q.size() > 0) begin
            mon_e  = sb_q.pop_front();
            checks = checks + 1;
            if (oCurPc !== mon_e.pc || oInst !== mon_e.inst) begin
                failures = failures + 1;
                $display("FAIL sb_inst: got pc=%h inst=%h, expected pc=%h inst=%h",
                         oCurPc, oInst, mon_e.pc, mon_e.inst);
            end
        end
    end

    task automatic do_reset(input int lat);
        iRst = 1'b1; iFlushPipe = 1'b0; iStall = 1'b0; iFlushPc = 32'h0;
        mem_lat = lat;
        repeat (5) @(negedge iClk);
        sb_q.delete();
        iRst = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge iClk);
        end
        ok = (sb_q.size() == 0);
    endtask

    task automatic test_reset;
        bit ok;
        iRst = 1'b1; mem_lat = 1;
        repeat (4) @(negedge iClk);
        #1;
        checks++;
        if ({oMemRd, oMemAddr} !== {1'b0, 32'h0}) begin
            failures++; $display("FAIL reset_mem: rd=%b addr=%h, expected rd=0 addr=0", oMemRd, oMemAddr);
        end
        checks++;
        if ({oInstDv, oInst, oCurPc} !== {1'b0, 32'h0, 32'h0}) begin
            failures++; $display("FAIL reset_out: dv=%b inst=%h pc=%h, expected zeros", oInstDv, oInst, oCurPc);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++;
        if (oMisalign !== 1'b0) begin
            failures++; $display("FAIL reset_misalign: got %b expected 0", oMisalign);
        end
`endif
        sb_expect(32'h0, 8);
        @(negedge iClk);
        iRst = 1'b0;
        #1;
        checks++;
        if (oMemRd !== 1'b0) begin
            failures++; $display("FAIL idle_rd: got %b expected 0", oMemRd);
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge iClk);
            #1;
            if (c <= 3) begin
                checks++;
                if (oMemRd !== 1'b1 || oMemAddr !== 32'(4 * (c - 1))) begin
                    failures++; $display("FAIL first_req c=%0d: rd=%b addr=%h, expected rd=1 addr=%h",
                                         c, oMemRd, oMemAddr, 32'(4 * (c - 1)));
                end
            end
            checks++;
            if (oInstDv !== (c >= 3)) begin
                failures++; $display("FAIL stream_dv c=%0d: got %b expected %b", c, oInstDv, (c >= 3));
            end
        end
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL stream_drain: %0d left, expected 0", sb_q.size());
        end
    endtask

    task automatic test_stall;
        bit ok;
        do_reset(1);
        sb_expect(32'h0, 16);
        repeat (5) @(negedge iClk);
        iStall = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            @(negedge iClk);
            #1;
            checks++;
            if (oMemRd !== 1'b0 || oInstDv !== 1'b1 || int'(dut.w_count) > cDepth) begin
                failures++; $display("FAIL stall s=%0d: rd=%b dv=%b cnt=%0d, expected rd=0 dv=1 cnt<=%0d",
                                     s, oMemRd, oInstDv, dut.w_count, cDepth);
            end
        end
        @(negedge iClk);
        iStall = 1'b0;
        wait_drain(60, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL stall_drain: %0d left, expected 0", sb_q.size());
        end
    endtask

    task automatic test_redirect_drain;
        bit ok;
        bit found;
        do_reset(3);
        sb_expect(32'h0, 3);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge iClk);
            #1;
            if (oMemRd && iMemGnt && oMemAddr == 32'h10) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL drain_req10: got no request 0x10, expected one");
        end
        @(negedge iClk);
        iFlushPipe = 1'b1; iFlushPc = 32'h100;
        sb_q.delete();
        sb_expect(32'h100, 3);
        #1;
        checks++;
        if (oMemRd !== 1'b0) begin
            failures++; $display("FAIL drain_flush_rd: got %b expected 0", oMemRd);
        end
        @(negedge iClk);
        iFlushPipe = 1'b0;
        #1;
        checks++;
        if (oMemRd !== 1'b0 || oInstDv !== 1'b0) begin
            failures++; $display("FAIL drain_wait: rd=%b dv=%b, expected 0 0", oMemRd, oInstDv);
        end
        @(negedge iClk);
        #1;
        checks++;
        if (oMemRd !== 1'b0) begin
            failures++; $display("FAIL drain_dv_rd: got %b expected 0", oMemRd);
        end
        @(negedge iClk);
        #1;
        checks++;
        if (oMemRd !== 1'b1 || oMemAddr !== 32'h100) begin
            failures++; $display("FAIL drain_resume: rd=%b addr=%h, expected rd=1 addr=00000100", oMemRd, oMemAddr);
        end
        wait_drain(60, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL drain_sb: %0d left, expected 0", sb_q.size());
        end
    endtask

    task automatic test_redirect_dv;
        bit ok;
        do_reset(1);
        sb_expect(32'h0, 2);
        repeat (6) @(negedge iClk);
        iFlushPipe = 1'b1; iFlushPc = 32'h200;
        sb_q.delete();
        sb_expect(32'h200, 4);
        #1;
        checks++;
        if (oMemRd !== 1'b0) begin
            failures++; $display("FAIL dvflush_rd: got %b expected 0", oMemRd);
        end
        @(negedge iClk);
        iFlushPipe = 1'b0;
        #1;
        checks++;
        if (oMemRd !== 1'b1 || oMemAddr !== 32'h200 || oInstDv !== 1'b0) begin
            failures++; $display("FAIL dvflush_next: rd=%b addr=%h dv=%b, expected 1 00000200 0", oMemRd, oMemAddr, oInstDv);
        end
        @(negedge iClk);
        #1;
        checks++;
        if (oInstDv !== 1'b0 || oMemAddr !== 32'h204) begin
            failures++; $display("FAIL dvflush_gap: dv=%b addr=%h, expected 0 00000204", oInstDv, oMemAddr);
        end
        @(negedge iClk);
        #1;
        checks++;
        if (oInstDv !== 1'b1 || oCurPc !== 32'h200) begin
            failures++; $display("FAIL dvflush_first: dv=%b pc=%h, expected 1 00000200", oInstDv, oCurPc);
        end
        wait_drain(40, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL dvflush_sb: %0d left, expected 0", sb_q.size());
        end
    endtask

    task automatic test_misalign;
        bit ok;
        do_reset(1);
        repeat (6) @(negedge iClk);
        iFlushPipe = 1'b1; iFlushPc = 32'h102;
        sb_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        #1;
        checks++;
        if (oMemRd !== 1'b0) begin
            failures++; $display("FAIL mis_flush_rd: got %b expected 0", oMemRd);
        end
        @(negedge iClk);
        iFlushPipe = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (oMisalign !== 1'b1 || oMemRd !== 1'b0 || oInstDv !== 1'b0) begin
                failures++; $display("FAIL mis_halt c=%0d: mis=%b rd=%b dv=%b, expected 1 0 0", c, oMisalign, oMemRd, oInstDv);
            end
            @(negedge iClk);
        end
        iFlushPipe = 1'b1; iFlushPc = 32'h200;
        sb_expect(32'h200, 3);
        @(negedge iClk);
        iFlushPipe = 1'b0;
        #1;
        checks++;
        if (oMemRd !== 1'b1 || oMemAddr !== 32'h200 || oMisalign !== 1'b0) begin
            failures++; $display("FAIL mis_resume: rd=%b addr=%h mis=%b, expected 1 00000200 0", oMemRd, oMemAddr, oMisalign);
        end
`else
        sb_expect(32'h100, 3);
        @(negedge iClk);
        iFlushPipe = 1'b0;
        #1;
        checks++;
        if (oMemRd !== 1'b1 || oMemAddr !== 32'h100) begin
            failures++; $display("FAIL mis_align: rd=%b addr=%h, expected 1 00000100", oMemRd, oMemAddr);
        end
`endif
        wait_drain(40, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL mis_sb: %0d left, expected 0", sb_q.size());
        end
    endtask

    task automatic test_wrap;
        bit ok;
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'hFFFF_FFF8;
        exp_addr[1] = 32'hFFFF_FFFC;
        exp_addr[2] = 32'h0000_0000;
        do_reset(1);
        repeat (3) @(negedge iClk);
        iFlushPipe = 1'b1; iFlushPc = 32'hFFFF_FFF8;
        sb_q.delete();
        sb_expect(32'hFFFF_FFF8, 4);
        @(negedge iClk);
        iFlushPipe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (oMemRd !== 1'b1 || oMemAddr !== exp_addr[k]) begin
                failures++; $display("FAIL wrap k=%0d: rd=%b addr=%h, expected 1 %h", k, oMemRd, oMemAddr, exp_addr[k]);
            end
            @(negedge iClk);
        end
        wait_drain(40, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL wrap_sb: %0d left, expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_drain();
        test_redirect_dv();
        test_misalign();
        test_wrap();
        checks++;
        if (ovf_cnt !== 0) begin
            failures++; $display("FAIL no_overflow: %0d pushes into full buffer, expected 0", ovf_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
